// File: rtl/hazard_if.sv
// Pipeline hazard-control bundle: ID/EX hazard sources in, stall/flush controls
// and status out. The master side drives the pipeline inputs and the slave is the controller.
interface hazard_if;
   logic [4:0]  ID_rs;
   logic [4:0]  ID_rt;
   logic        ID_useRt;
   logic        EX_memRead;
   logic [4:0]  EX_rt;
   logic        branch_taken;
   logic        jump;
   logic        mem_busy;
   logic        pc_write;
   logic        IF_ID_write;
   logic        IF_ID_flush;
   logic        ID_EX_ctrl_zero;
   logic        pipe_hold;
   logic [1:0]  state;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
   logic        mem_timeout;

   modport master (
      output ID_rs, ID_rt, ID_useRt, EX_memRead, EX_rt, branch_taken, jump, mem_busy,
      input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_ctrl_zero, pipe_hold,
      input  state, stall_cnt, flush_cnt, mem_timeout
   );

   modport slave (
      input  ID_rs, ID_rt, ID_useRt, EX_memRead, EX_rt, branch_taken, jump, mem_busy,
      output pc_write, IF_ID_write, IF_ID_flush, ID_EX_ctrl_zero, pipe_hold,
      output state, stall_cnt, flush_cnt, mem_timeout
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch/jump flushes,
// memory-wait freezing, saturating stall/flush statistics and a sticky memory timeout.
module hazard_ctrl #(
   parameter int TIMEOUT = 16
) (
   input logic clk,
   input logic rst,
   hazard_if.slave hz
);

   localparam logic [1:0] RUN        = 2'd0;
   localparam logic [1:0] LOAD_STALL = 2'd1;
   localparam logic [1:0] MEM_WAIT   = 2'd2;
   localparam logic [4:0] TIMEOUT_LIM = 5'(TIMEOUT);

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic [15:0] stall_cnt_r;
   logic [15:0] flush_cnt_r;
   logic [4:0]  wait_cnt_r;
   logic [4:0]  wait_nxt_s;
   logic        mem_timeout_r;
   logic        load_use_s;
   logic        load_use_eff_s;
   logic        pc_write_s;
   logic        if_id_write_s;
   logic        if_id_flush_s;
   logic        ctrl_zero_s;
   logic        pipe_hold_s;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign load_use_s = hz.EX_memRead & (hz.EX_rt != 5'd0) &
                       ((hz.EX_rt == hz.ID_rs) | (hz.ID_useRt & (hz.EX_rt == hz.ID_rt)));

   // The instruction held by a load-use stall must not stall a second time.
   assign load_use_eff_s = load_use_s & (state_r != LOAD_STALL);

   // Prioritised pipeline controls and next-state selection.
   always_comb begin
      pc_write_s    = 1'b1;
      if_id_write_s = 1'b1;
      if_id_flush_s = 1'b0;
      ctrl_zero_s   = 1'b0;
      pipe_hold_s   = 1'b0;
      state_nxt_s   = RUN;
      if (rst) begin
         pc_write_s    = 1'b0;
         if_id_write_s = 1'b0;
      end else if (hz.mem_busy) begin
         pc_write_s    = 1'b0;
         if_id_write_s = 1'b0;
         pipe_hold_s   = 1'b1;
         state_nxt_s   = MEM_WAIT;
      end else if (load_use_eff_s) begin
         pc_write_s    = 1'b0;
         if_id_write_s = 1'b0;
         ctrl_zero_s   = 1'b1;
         state_nxt_s   = LOAD_STALL;
      end else if (hz.branch_taken | hz.jump) begin
         if_id_flush_s = 1'b1;
      end else begin
         state_nxt_s = RUN;
      end
   end

   // Consecutive MEM_WAIT cycle count, saturating so the timeout compare cannot wrap.
   always_comb begin
      wait_nxt_s = 5'd0;
      if (state_nxt_s == MEM_WAIT) begin
         wait_nxt_s = (wait_cnt_r == 5'd31) ? wait_cnt_r : wait_cnt_r + 5'd1;
      end else begin
         wait_nxt_s = 5'd0;
      end
   end

   // State, statistics counters and the sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= RUN;
         stall_cnt_r   <= 16'd0;
         flush_cnt_r   <= 16'd0;
         wait_cnt_r    <= 5'd0;
         mem_timeout_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_nxt_s;
         if (!pc_write_s) begin
            stall_cnt_r <= sat_inc16(stall_cnt_r);
         end
         if (if_id_flush_s) begin
            flush_cnt_r <= sat_inc16(flush_cnt_r);
         end
         if ((state_nxt_s == MEM_WAIT) && (wait_nxt_s == TIMEOUT_LIM)) begin
            mem_timeout_r <= 1'b1;
         end
      end
   end

   assign hz.pc_write        = pc_write_s;
   assign hz.IF_ID_write     = if_id_write_s;
   assign hz.IF_ID_flush     = if_id_flush_s;
   assign hz.ID_EX_ctrl_zero = ctrl_zero_s;
   assign hz.pipe_hold       = pipe_hold_s;
   assign hz.state           = state_r;
   assign hz.stall_cnt       = stall_cnt_r;
   assign hz.flush_cnt       = flush_cnt_r;
   assign hz.mem_timeout     = mem_timeout_r;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: number of consecutive MEM_WAIT cycles after which mem_timeout sets.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ID_rs  input  5  rs field of the instruction in ID.
REQ-005 ID_rt  input  5  rt field of the instruction in ID.
REQ-006 ID_useRt  input  1  ID instruction reads rt as a source.
REQ-007 EX_memRead  input  1  instruction in EX is a load.
REQ-008 EX_rt  input  5  destination register of the load in EX.
REQ-009 branch_taken  input  1  branch in ID resolved taken this cycle.
REQ-010 jump  input  1  jump decoded in ID this cycle.
REQ-011 mem_busy  input  1  data memory not ready this cycle.
REQ-012 pc_write  output  1  PC update enable.
REQ-013 IF_ID_write  output  1  IF/ID register write enable.
REQ-014 IF_ID_flush  output  1  IF/ID flush; meaningful only with IF_ID_write=1.
REQ-015 ID_EX_ctrl_zero  output  1  inject bubble (zero control) into ID/EX.
REQ-016 pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB.
REQ-017 state  output  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT.
REQ-018 stall_cnt  output  16  count of cycles with pc_write=0 while rst=0.
REQ-019 flush_cnt  output  16  count of cycles with IF_ID_flush=1.
REQ-020 mem_timeout  output  1  sticky memory-timeout error flag.

Function
REQ-021 The block SHALL define load_use = EX_memRead & (EX_rt!=0) & ((EX_rt==ID_rs) | (ID_useRt & (EX_rt==ID_rt))).
REQ-022 Outputs 012-016 SHALL be combinational from state and inputs in the same cycle, with priority mem_busy > load_use > (branch_taken|jump) > normal.
REQ-023 On mem_busy=1 in any state: pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_ctrl_zero=0, pipe_hold=1; next state MEM_WAIT.
REQ-024 In RUN with mem_busy=0 and load_use=1: pc_write=0, IF_ID_write=0, ID_EX_ctrl_zero=1, IF_ID_flush=0, pipe_hold=0; next state LOAD_STALL.
REQ-025 In LOAD_STALL, load_use SHALL be masked; other rules apply as in RUN; next state RUN unless mem_busy=1.
REQ-026 With mem_busy=0, no unmasked load_use, and branch_taken|jump=1: pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_ctrl_zero=0, pipe_hold=0.
REQ-027 Normal case: pc_write=1, IF_ID_write=1, all other control outputs 0; next state RUN.
REQ-028 Branch coincident with load_use SHALL NOT flush; the held branch is re-evaluated the following cycle.
REQ-029 In MEM_WAIT with mem_busy=0, outputs and next state SHALL follow RUN rules in that same cycle, with no extra bubble.
REQ-030 A 5-bit wait counter SHALL count consecutive cycles in MEM_WAIT and clear on leaving it.
REQ-031 mem_timeout SHALL set on the edge at which the wait counter reaches TIMEOUT, and hold until reset.
REQ-032 stall_cnt and flush_cnt SHALL saturate at 16'hFFFF, never wrapping.

Reset
REQ-033 While rst=1: state=RUN, stall_cnt=0, flush_cnt=0, wait counter=0, mem_timeout=0.
REQ-034 While rst=1: pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_ctrl_zero=0, pipe_hold=0.
REQ-035 Reset asserted mid-MEM_WAIT or mid-LOAD_STALL SHALL return to RUN immediately without waiting for a clock edge.

Verification
REQ-036 Load-use: EX_memRead=1, EX_rt=5, ID_rs=5 -> one cycle with pc_write=0, IF_ID_write=0, ID_EX_ctrl_zero=1, state->1, then RUN; stall_cnt=1.
REQ-037 EX_rt=0 with ID_rs=0 and EX_memRead=1 -> no stall; ID_useRt=0 with rt match only -> no stall.
REQ-038 Branch: branch_taken=1 for 1 cycle -> IF_ID_flush=1, IF_ID_write=1, pc_write=1; flush_cnt=1. Branch with load_use -> stall first, flush next cycle.
REQ-039 mem_busy high 3 cycles -> pipe_hold=1, pc_write=0 for 3 cycles, state=2; RUN on release; stall_cnt=3.
REQ-040 mem_busy held 16 cycles -> mem_timeout=1 after 16th edge; stays 1 after release until rst.
REQ-041 Force 70000 stall cycles -> stall_cnt=16'hFFFF; async rst mid-MEM_WAIT -> state=0, counters 0 immediately.
